// File: rtl/systolic_result_collector.sv
// Reassembles skewed column results from the systolic array into NxN rows; a row is presented the cycle after its last element lands.
// Rows stream out in order on valid/ready and are held stable while stalled; writes to a full column are dropped and flag overflow.
module systolic_result_collector #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [MATRIX_SIZE-1:0]                                 col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0]                       col_data,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0]                       out_data,
    output logic [((MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1)-1:0] out_row,
    output logic                                                   out_last,
    output logic                                                   done,
    output logic                                                   busy,
    output logic                                                   overflow
);
    localparam int N  = MATRIX_SIZE;
    localparam int WW = $clog2(N + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic [DATA_SIZE-1:0] buf_q [N][N];
    logic [DATA_SIZE-1:0] buf_d [N][N];
    logic [WW-1:0]        wcnt_q [N];
    logic [WW-1:0]        wcnt_d [N];
    logic [RW-1:0]        rptr_q, rptr_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 row_cplt;
    logic                 any_busy;
    logic                 transfer;
    logic                 last_xfer;

    // Presentation logic looks only at registered state, never at the column inputs.
    always_comb begin
        row_cplt = 1'b1;
        any_busy = (rptr_q != '0);
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            if (wcnt_q[j] <= WW'(rptr_q)) row_cplt = 1'b0;
            if (wcnt_q[j] != '0) any_busy = 1'b1;
            out_data[j*DATA_SIZE +: DATA_SIZE] = buf_q[rptr_q][j];
        end
    end

    assign out_valid = row_cplt;
    assign out_row   = rptr_q;
    assign out_last  = (rptr_q == RW'(N - 1));
    assign busy      = any_busy;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign transfer  = out_valid && out_ready;
    assign last_xfer = transfer && out_last;

    always_comb begin
        buf_d      = buf_q;
        wcnt_d     = wcnt_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        done_d     = last_xfer;
        for (int j = 0; j < N; j++) begin
            if (col_valid[j]) begin
                if (wcnt_q[j] == WW'(N)) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (wcnt_q[j] == WW'(i)) buf_d[i][j] = col_data[j*DATA_SIZE +: DATA_SIZE];
                    end
                    wcnt_d[j] = wcnt_q[j] + WW'(1);
                end
            end
        end
        if (transfer) rptr_d = rptr_q + RW'(1);
        // Final row leaving rearms every column; a write in this cycle hit a full column and was dropped above.
        if (last_xfer) begin
            rptr_d = '0;
            for (int j = 0; j < N; j++) wcnt_d[j] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int j = 0; j < N; j++) wcnt_q[j] <= '0;
        end else begin
            rptr_q     <= rptr_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            wcnt_q     <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector at N=2, 32-bit elements.
module tb_systolic_result_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  col_valid;
    logic [63:0] col_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [0:0]  out_row;
    logic        out_last;
    logic        done;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004, E = 32'hEEEE_0005, F = 32'hFFFF_0006;
    localparam logic [31:0] G = 32'h1234_5678, H = 32'h8000_0000;

    always #5 clk = ~clk;

    systolic_result_collector #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut (
        .clk(clk), .reset(reset), .col_valid(col_valid), .col_data(col_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .done(done), .busy(busy),
        .overflow(overflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] cv, input logic [31:0] d1, input logic [31:0] d0, input logic rdy);
        col_valid = cv;
        col_data  = {d1, d0};
        out_ready = rdy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_in(2'($urandom), $urandom, $urandom, 1'($urandom));
            cyc();
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if ({out_row, out_last} !== 2'b00) begin errors++; $display("FAIL reset_row_last got %b exp 00", {out_row, out_last}); end
        cyc();
        reset = 1'b0;
        set_in(2'b00, 0, 0, 1'b0);
    endtask

    task automatic test_skewed();
        set_in(2'b01, 0, A, 1'b1);
        @(negedge clk);
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL skew_c0 valid,busy got %b exp 00", {out_valid, busy}); end
        cyc();
        set_in(2'b11, C, B, 1'b1);
        @(negedge clk);
        checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL skew_c1 valid,busy got %b exp 01", {out_valid, busy}); end
        cyc();
        set_in(2'b10, D, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL skew_c2_valid got %0b exp 1", out_valid); end
        checks++; if (out_data !== {C, A}) begin errors++; $display("FAIL skew_c2_data got %h exp %h", out_data, {C, A}); end
        checks++; if ({out_row, out_last} !== 2'b00) begin errors++; $display("FAIL skew_c2_row_last got %b exp 00", {out_row, out_last}); end
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {D, B}) begin errors++; $display("FAIL skew_c3_data got %h exp %h", out_data, {D, B}); end
        checks++; if ({out_valid, out_row, out_last, done} !== 4'b1110) begin errors++; $display("FAIL skew_c3 valid,row,last,done got %b exp 1110", {out_valid, out_row, out_last, done}); end
        cyc();
        @(negedge clk);
        checks++; if ({done, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL skew_c4 done,busy,valid got %b exp 100", {done, busy, out_valid}); end
        cyc();
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL skew_c5_done_pulse got %0b exp 0", done); end
        cyc();
    endtask

    task automatic test_backpressure();
        set_in(2'b01, 0, A, 1'b0);
        cyc();
        set_in(2'b11, C, B, 1'b0);
        cyc();
        set_in(2'b10, D, 0, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            checks++; if ({out_valid, out_row} !== 2'b10 || out_data !== {C, A}) begin
                errors++; $display("FAIL bp_hold_c%0d valid=%0b row=%0d data=%h exp valid=1 row=0 data=%h", c, out_valid, out_row, out_data, {C, A});
            end
            cyc();
            set_in(2'b00, 0, 0, 1'b0);
        end
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {C, A} || out_valid !== 1'b1) begin errors++; $display("FAIL bp_c7 data=%h valid=%0b exp data=%h valid=1", out_data, out_valid, {C, A}); end
        cyc();
        @(negedge clk);
        checks++; if (out_data !== {D, B} || {out_valid, out_last, done} !== 3'b110) begin
            errors++; $display("FAIL bp_c8 data=%h valid,last,done=%b exp data=%h 110", out_data, {out_valid, out_last, done}, {D, B});
        end
        cyc();
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL bp_c9 done,busy got %b exp 10", {done, busy}); end
        cyc();
    endtask

    task automatic test_overflow();
        set_in(2'b01, 0, A, 1'b0);
        cyc();
        set_in(2'b11, C, B, 1'b0);
        cyc();
        set_in(2'b10, D, 0, 1'b0);
        cyc();
        set_in(2'b01, 0, E, 1'b0);
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %0b exp 0", overflow); end
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end
        checks++; if (out_data !== {C, A}) begin errors++; $display("FAIL ovf_row0 got %h exp %h", out_data, {C, A}); end
        cyc();
        @(negedge clk);
        checks++; if (out_data !== {D, B} || out_last !== 1'b1) begin errors++; $display("FAIL ovf_row1 data=%h last=%0b exp %h 1", out_data, out_last, {D, B}); end
        cyc();
        set_in(2'b00, 0, 0, 1'b0);
        @(negedge clk);
        checks++; if ({done, overflow} !== 2'b11) begin errors++; $display("FAIL ovf_sticky done,overflow got %b exp 11", {done, overflow}); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
        cyc();
    endtask

    task automatic test_reset_mid();
        set_in(2'b01, 0, A, 1'b1);
        cyc();
        set_in(2'b11, C, B, 1'b1);
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL rmid_after busy,valid got %b exp 00", {busy, out_valid}); end
        cyc();
        set_in(2'b11, F, E, 1'b1);
        cyc();
        set_in(2'b11, H, G, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== {F, E}) begin errors++; $display("FAIL rmid_row0 valid=%0b data=%h exp 1 %h", out_valid, out_data, {F, E}); end
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {H, G} || {out_row, out_last} !== 2'b11) begin errors++; $display("FAIL rmid_row1 data=%h row,last=%b exp %h 11", out_data, {out_row, out_last}, {H, G}); end
        cyc();
        @(negedge clk);
        checks++; if ({done, busy, overflow} !== 3'b100) begin errors++; $display("FAIL rmid_done done,busy,ovf got %b exp 100", {done, busy, overflow}); end
        cyc();
    endtask

    task automatic test_back_to_back();
        set_in(2'b11, C, A, 1'b1);
        cyc();
        set_in(2'b11, D, B, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {C, A}) begin errors++; $display("FAIL b2b_m1_row0 got %h exp %h", out_data, {C, A}); end
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {D, B} || out_last !== 1'b1) begin errors++; $display("FAIL b2b_m1_row1 data=%h last=%0b exp %h 1", out_data, out_last, {D, B}); end
        cyc();
        set_in(2'b11, F, E, 1'b1);
        @(negedge clk);
        checks++; if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL b2b_done_cycle done,valid got %b exp 10", {done, out_valid}); end
        cyc();
        set_in(2'b11, H, G, 1'b1);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== {F, E} || out_row !== 1'b0) begin
            errors++; $display("FAIL b2b_m2_row0 valid=%0b row=%0d data=%h exp 1 0 %h", out_valid, out_row, out_data, {F, E});
        end
        checks++; if ({overflow, done} !== 2'b00) begin errors++; $display("FAIL b2b_ovf_done got %b exp 00", {overflow, done}); end
        cyc();
        set_in(2'b00, 0, 0, 1'b1);
        @(negedge clk);
        checks++; if (out_data !== {H, G} || out_last !== 1'b1) begin errors++; $display("FAIL b2b_m2_row1 data=%h last=%0b exp %h 1", out_data, out_last, {H, G}); end
        cyc();
        @(negedge clk);
        checks++; if ({done, busy, overflow} !== 3'b100) begin errors++; $display("FAIL b2b_m2_done done,busy,ovf got %b exp 100", {done, busy, overflow}); end
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        set_in(2'b00, 0, 0, 1'b0);
        test_reset();
        test_skewed();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
